// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, funct
// codes, ALU operation codes, datapath mux encodings and the FSM states.
package mips_ctrl_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operations
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-input select
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // ALU decoder class select
  localparam logic [1:0] ALU_CLS_FETCH  = 2'd0;
  localparam logic [1:0] ALU_CLS_BRANCH = 2'd1;
  localparam logic [1:0] ALU_CLS_R      = 2'd2;
  localparam logic [1:0] ALU_CLS_I      = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EXEC  = 4'd6,
    S_R_WB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_I_EXEC  = 4'd9,
    S_I_WB    = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // True for the R-type funct codes this control unit implements.
  function automatic logic is_r_funct(input logic [5:0] funct);
    logic ok;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_cu_alu_decoder.sv
// Combinational ALU operation decoder: picks the ALU op from the latched
// opcode/funct according to which class of state is using the ALU.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_cls,
  input  logic [5:0] op_code,
  input  logic [5:0] op_funct,
  output logic [2:0] alu_op
);

  // Select ALU operation by state class, then by funct or opcode.
  always_comb begin
    alu_op = ALU_ADD;
    case (alu_cls)
      ALU_CLS_BRANCH: alu_op = ALU_SUB;
      ALU_CLS_R: begin
        case (op_funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      ALU_CLS_I: begin
        case (op_code)
          OP_ADDI: alu_op = ALU_ADD;
          OP_SLTI: alu_op = ALU_SLT;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control unit. Moore FSM sequencing fetch, decode,
// execute, memory and write-back with memory wait states. Outputs are
// decoded from the state (plus mem_ready/zero_in where noted) and are
// forced to zero while rst is high so no strobe survives a reset.
module multicycle_cu
  import mips_ctrl_pkg::*;
#(
  parameter bit EN_JUMP      = 1'b1,
  parameter bit EN_IMM_LOGIC = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_code,
  input  logic [5:0] op_funct,
  input  logic       zero_in,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state_o
);

  state_t     state_r;
  logic [5:0] op_r;
  logic [5:0] funct_r;
  state_t     dec_next_s;
  logic       dec_illegal_s;
  logic [1:0] alu_cls_s;
  logic [2:0] alu_dec_op_s;

  // Decode the freshly loaded IR (live inputs) into the post-DECODE state.
  always_comb begin
    dec_next_s    = S_FETCH;
    dec_illegal_s = 1'b0;
    case (op_code)
      OP_LW, OP_SW:     dec_next_s = S_MEM_ADR;
      OP_BEQ, OP_BNE:   dec_next_s = S_BRANCH;
      OP_ADDI, OP_SLTI: dec_next_s = S_I_EXEC;
      OP_RTYPE: begin
        if (is_r_funct(op_funct)) begin
          dec_next_s = S_R_EXEC;
        end else begin
          dec_illegal_s = 1'b1;
        end
      end
      OP_ANDI, OP_ORI: begin
        if (EN_IMM_LOGIC) begin
          dec_next_s = S_I_EXEC;
        end else begin
          dec_illegal_s = 1'b1;
        end
      end
      OP_J: begin
        if (EN_JUMP) begin
          dec_next_s = S_JUMP;
        end else begin
          dec_illegal_s = 1'b1;
        end
      end
      default: dec_illegal_s = 1'b1;
    endcase
  end

  // State register and opcode/funct latch; unreachable codes fall back to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
      op_r    <= 6'd0;
      funct_r <= 6'd0;
    end else begin
      case (state_r)
        S_FETCH:   if (mem_ready) state_r <= S_DECODE;
        S_DECODE: begin
          op_r    <= op_code;
          funct_r <= op_funct;
          state_r <= dec_next_s;
        end
        S_MEM_ADR: state_r <= (op_r == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  if (mem_ready) state_r <= S_MEM_WB;
        S_MEM_WR:  if (mem_ready) state_r <= S_FETCH;
        S_R_EXEC:  state_r <= S_R_WB;
        S_I_EXEC:  state_r <= S_I_WB;
        default:   state_r <= S_FETCH;
      endcase
    end
  end

  // Choose which ALU decode rule applies in the current state.
  always_comb begin
    case (state_r)
      S_BRANCH: alu_cls_s = ALU_CLS_BRANCH;
      S_R_EXEC: alu_cls_s = ALU_CLS_R;
      S_I_EXEC: alu_cls_s = ALU_CLS_I;
      default:  alu_cls_s = ALU_CLS_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_cls  (alu_cls_s),
    .op_code  (op_r),
    .op_funct (funct_r),
    .alu_op   (alu_dec_op_s)
  );

  // Moore output decode; everything held at zero during reset.
  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = 3'b000;
    pc_src     = PC_SRC_ALU;
    pc_en      = 1'b0;
    illegal    = 1'b0;
    instr_done = 1'b0;
    state_o    = 4'd0;
    if (rst) begin
      state_o = 4'd0;
    end else begin
      state_o = state_r;
      case (state_r)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_op    = alu_dec_op_s;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM_SH2;
          alu_op     = alu_dec_op_s;
          illegal    = dec_illegal_s;
          instr_done = dec_illegal_s;
        end
        S_MEM_ADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = alu_dec_op_s;
        end
        S_MEM_RD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_RT;
          alu_op    = alu_dec_op_s;
        end
        S_R_WB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_RT;
          alu_op     = alu_dec_op_s;
          pc_src     = PC_SRC_ALUOUT;
          pc_en      = ((op_r == OP_BEQ) & zero_in) | ((op_r == OP_BNE) & ~zero_in);
          instr_done = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = alu_dec_op_s;
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_src     = PC_SRC_JUMP;
          pc_en      = 1'b1;
          instr_done = 1'b1;
        end
        default: begin
          state_o = state_r;
        end
      endcase
    end
  end

endmodule
